// File: rtl/limn2600_cache.sv
// Direct-mapped, write-through, one-word-per-line cache between the Limn2600 CPU and DRAM.
// Read misses allocate; writes always go to DRAM and refresh the cached copy only on a hit.
module limn2600_cache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {IDLE, MEMRD, MEMWR, RESP} state_t;

    state_t state;
    state_t next_state;

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags [LINES];
    logic [31:0]      data [LINES];

    logic [31:0] addr_q;
    logic        we_q;
    logic        hit_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [IDX-1:0]  idx_in;
    logic [TAGW-1:0] tag_in;
    logic [IDX-1:0]  idx_q;
    logic [TAGW-1:0] tag_q;
    logic            lookup_hit;

    assign idx_in     = cpu_addr[IDX+1:2];
    assign tag_in     = cpu_addr[31:IDX+2];
    assign idx_q      = addr_q[IDX+1:2];
    assign tag_q      = addr_q[31:IDX+2];
    assign lookup_hit = valid[idx_in] && (tags[idx_in] == tag_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        next_state = MEMWR;
                    end else if (lookup_hit) begin
                        next_state = RESP;
                    end else begin
                        next_state = MEMRD;
                    end
                end
            end
            MEMRD: if (mem_rdy) next_state = RESP;
            MEMWR: if (mem_rdy) next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode purely from registered state and latched request, so they hold steady per request.
    always_comb begin
        cpu_rdy   = 1'b0;
        cpu_rdata = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (state)
            MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q & 32'hFFFF_FFFC;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q & 32'hFFFF_FFFC;
                mem_wdata = wdata_q;
            end
            RESP: begin
                cpu_rdy   = 1'b1;
                cpu_rdata = we_q ? 32'h0 : rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        hit_q   <= lookup_hit;
                        if (!cpu_we) begin
                            if (lookup_hit) begin
                                rdata_q   <= data[idx_in];
                                hit_count <= hit_count + 16'd1;
                            end else begin
                                miss_count <= miss_count + 16'd1;
                            end
                        end
                    end
                end
                MEMRD: begin
                    if (mem_rdy) begin
                        valid[idx_q] <= 1'b1;
                        rdata_q      <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; a reset cycle only has to block writes into them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == MEMRD && mem_rdy) begin
                data[idx_q] <= mem_rdata;
                tags[idx_q] <= tag_q;
            end else if (state == MEMWR && mem_rdy && hit_q) begin
                data[idx_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_limn2600_cache.sv
// Directed bench for limn2600_cache: a latency-driven DRAM responder plus an expected-read-data queue.
module tb_limn2600_cache;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_rdy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rdy = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [31:0] dram [logic [31:0]];
    logic [31:0] exp_q [$];

    int          check_count = 0;
    int          pass_count = 0;
    int          txn_count = 0;
    int          wait_cnt = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        last_we = 1'b0;

    limn2600_cache #(.LINES(64)) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_rdy(cpu_rdy),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // DRAM model: answers LAT cycles after mem_req first appears, one-cycle mem_rdy pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_rdy) begin
                mem_rdy = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt == LAT) begin
                    wait_cnt   = 0;
                    last_addr  = mem_addr;
                    last_we    = mem_we;
                    last_wdata = mem_wdata;
                    if (mem_we) begin
                        dram[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = dram.exists(mem_addr) ? dram[mem_addr] : 32'h0;
                    end
                    mem_rdy   = 1'b1;
                    txn_count = txn_count + 1;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count = check_count + 1;
        assert (observed === expected) pass_count = pass_count + 1;
        else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // One CPU access: queue the expected read data, hold cpu_req until cpu_rdy, then score it.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_mem);
        int          cycles;
        int          txn_before;
        logic        seen;
        logic [31:0] got;
        logic [31:0] want;
        cycles     = 0;
        seen       = 1'b0;
        got        = 32'h0;
        txn_before = txn_count;
        exp_q.push_back(exp_rdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        while (!seen && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
            if (cpu_rdy) begin
                seen = 1'b1;
                got  = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        want = exp_q.pop_front();
        checkOutput({tag, "_rdy_seen"}, 32'(seen), 32'h1);
        if (seen) begin
            checkOutput({tag, "_rdata"}, got, want);
            checkOutput({tag, "_latency"}, 32'(cycles), exp_mem ? 32'(LAT + 2) : 32'h1);
        end
        checkOutput({tag, "_dram_txns"}, 32'(txn_count - txn_before), 32'(exp_mem));
        @(posedge clk);
        #1;
        checkOutput({tag, "_rdy_pulse"}, 32'(cpu_rdy), 32'h0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_cpu_rdy"}, 32'(cpu_rdy), 32'h0);
        checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_hit_count"}, 32'(hit_count), 32'h0);
        checkOutput({tag, "_miss_count"}, 32'(miss_count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cycles;
        logic req_seen;
        dram[32'h100] = 32'hDEADBEEF;
        dram[32'h200] = 32'h11111111;

        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;

        applyStimulus("cold_miss", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
        checkOutput("cold_miss_mem_addr", last_addr, 32'h100);
        checkOutput("cold_miss_mem_we", 32'(last_we), 32'h0);
        checkOutput("cold_miss_count", 32'(miss_count), 32'h1);

        applyStimulus("hit_aligned", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus("hit_unaligned", 1'b0, 32'h102, 32'h0, 32'hDEADBEEF, 1'b0);
        checkOutput("hit_count_two", 32'(hit_count), 32'h2);

        applyStimulus("conflict_200", 1'b0, 32'h200, 32'h0, 32'h11111111, 1'b1);
        checkOutput("conflict_200_addr", last_addr, 32'h200);
        applyStimulus("conflict_100", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
        checkOutput("conflict_100_addr", last_addr, 32'h100);
        checkOutput("conflict_miss_count", 32'(miss_count), 32'h3);

        applyStimulus("write_hit", 1'b1, 32'h100, 32'h12345678, 32'h0, 1'b1);
        checkOutput("write_hit_mem_we", 32'(last_we), 32'h1);
        checkOutput("write_hit_mem_wdata", last_wdata, 32'h12345678);
        checkOutput("write_hit_mem_addr", last_addr, 32'h100);
        applyStimulus("read_after_write", 1'b0, 32'h100, 32'h0, 32'h12345678, 1'b0);
        checkOutput("write_hit_counts", 32'(hit_count), 32'h3);

        applyStimulus("write_miss", 1'b1, 32'h300, 32'hCAFEF00D, 32'h0, 1'b1);
        checkOutput("write_miss_mem_addr", last_addr, 32'h300);
        checkOutput("write_miss_mem_wdata", last_wdata, 32'hCAFEF00D);
        applyStimulus("read_after_wmiss", 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 1'b1);
        checkOutput("read_after_wmiss_we", 32'(last_we), 32'h0);
        checkOutput("wmiss_miss_count", 32'(miss_count), 32'h4);
        checkOutput("wmiss_hit_count", 32'(hit_count), 32'h3);

        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h400;
        cycles   = 0;
        req_seen = 1'b0;
        while (!req_seen && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
            if (mem_req) req_seen = 1'b1;
        end
        checkOutput("rst_mid_memreq", 32'(req_seen), 32'h1);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        checkIdleOutputs("rst_mid");
        rst = 1'b0;

        applyStimulus("post_reset_read", 1'b0, 32'h100, 32'h0, 32'h12345678, 1'b1);
        checkOutput("post_reset_miss_count", 32'(miss_count), 32'h1);
        checkOutput("post_reset_hit_count", 32'(hit_count), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/limn2600_cache.md
# limn2600_cache

Direct-mapped, write-through, one-word-per-line cache between `limn2600_cpu` and `limn2600_dram` in the Limn2600 SoC. Read hits complete without a DRAM access. Read misses fill a line from DRAM. Every write is forwarded to DRAM, and on a write hit the cached copy is also updated.

## Interface
- `LINES`, default 64: number of lines; must be a power of two. `IDX = log2(LINES)`.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `cpu_req`, in, 1: CPU access request; held until `cpu_rdy`.
- `cpu_we`, in, 1: 1 = write, 0 = read.
- `cpu_addr`, in, 32: byte address; bits [1:0] are ignored.
- `cpu_wdata`, in, 32: write data.
- `cpu_rdata`, out, 32: read data; valid while `cpu_rdy` is high.
- `cpu_rdy`, out, 1: one-cycle completion pulse.
- `mem_req`, out, 1: DRAM request; held until `mem_rdy`.
- `mem_we`, out, 1: DRAM write enable.
- `mem_addr`, out, 32: word-aligned DRAM address.
- `mem_wdata`, out, 32: DRAM write data.
- `mem_rdata`, in, 32: DRAM read data; valid while `mem_rdy` is high.
- `mem_rdy`, in, 1: DRAM one-cycle completion pulse.
- `hit_count`, out, 16: read-hit counter; wraps.
- `miss_count`, out, 16: read-miss counter; wraps.

## Operation
- Address fields: index = `addr[IDX+1:2]`; tag = `addr[31:IDX+2]`.
- Storage per line: valid bit, tag, 32-bit data word. Arrays are read combinationally from the index.
- FSM states: IDLE, MEMRD, MEMWR, RESP.
- IDLE:
  - Ignores the request when `cpu_req` is 0.
  - On `cpu_req`=1, latches addr, we, wdata and the hit result.
  - Read hit goes to RESP with the line data, and `hit_count` increments.
  - Read miss goes to MEMRD, and `miss_count` increments.
  - Any write goes to MEMWR.
- MEMRD:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr` = {latched addr[31:2], 2'b00}.
  - On `mem_rdy`, writes data, tag and valid=1 into the line, captures `mem_rdata`, and goes to RESP.
- MEMWR:
  - Drives `mem_req`=1, `mem_we`=1, the same aligned `mem_addr`, and `mem_wdata` = latched wdata.
  - On `mem_rdy`, if the latched hit is set, updates the line data with wdata. No allocation on a write miss.
  - Then goes to RESP.
- RESP:
  - Drives `cpu_rdy`=1 for exactly one cycle. `cpu_rdata` = captured word on reads, 0 on writes.
  - `cpu_req` is not sampled in this state.
  - Next state is IDLE.
- Counters count only read accesses. Writes do not count.
- Reset behaviour:
  - Clears every valid bit, counters = 0, state = IDLE.
  - `cpu_rdy`, `cpu_rdata`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` all = 0.
  - A reset during MEMRD or MEMWR abandons the DRAM transaction. DRAM shares `rst`. No line is modified.
- A `mem_rdy` arriving while not in MEMRD/MEMWR is ignored.
- Data and tag arrays are not reset; only valid bits are.

## Timing
- All state changes occur on the rising `clk` edge.
- Read hit: `cpu_req` sampled at edge 0, then `cpu_rdy` is high in the cycle after edge 0. Latency is 1 cycle.
- Read miss:
  - `mem_req` rises in the cycle after edge 0.
  - Line is filled at the edge where `mem_rdy`=1.
  - `cpu_rdy` is high in the cycle after that edge.
  - Latency is DRAM latency + 2.
- Write: same timing as a read miss.
- `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are registered, stable for the whole request, and drop at the edge that sees `mem_rdy`.
- Throughput:
  - Earliest next `cpu_req` sample is the edge ending the RESP cycle.
  - Back-to-back hits: one access per 2 cycles.
- Simultaneous `rst` and `mem_rdy`: reset wins, and nothing is filled.

## Test plan
- Cold read miss:
  - Reset, then read 0x100.
  - DRAM returns 0xDEADBEEF 3 cycles after `mem_req`.
  - Required: `mem_addr`=0x100 with `mem_we`=0; `cpu_rdy` pulse 1 cycle after `mem_rdy` with `cpu_rdata`=0xDEADBEEF; `miss_count`=1.
- Hit and alignment:
  - Read 0x100, then 0x102.
  - Required: no `mem_req`; `cpu_rdy` 1 cycle after the sample; data 0xDEADBEEF both times; `hit_count`=2.
- Conflict (`LINES`=64):
  - Read 0x200, DRAM returns 0x11111111, then read 0x100.
  - Required: both accesses miss with DRAM reads; 0x100 returns the DRAM value again.
- Write hit:
  - With 0x100 cached, write 0x12345678 to 0x100.
  - Required: `mem_we`=1, `mem_wdata`=0x12345678; a following read of 0x100 hits and returns 0x12345678.
- Write miss (no allocate):
  - Write 0xCAFEF00D to 0x300, then read 0x300.
  - Required: the read is a miss and issues a DRAM read.
- Reset during miss:
  - Assert `rst` while `mem_req`=1 in MEMRD.
  - Required: next cycle all outputs = 0 and counters = 0; a later read of 0x100 misses.
